// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions for the display encode and scan-decode paths.
// Segment patterns are active low, ordered g..a (bit6 = g, bit0 = a).
package ssd_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // What a committed dwell does to its digit slot.
  typedef enum logic [1:0] {
    CommitNone,
    CommitHex,
    CommitBlank,
    CommitErr
  } commit_e;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational inverse of the segment encoder: active-low cathodes to a hex code.
// Patterns that are neither a hex glyph nor blank report is_hex = is_blank = 0.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [SEG_W-1:0]  cc,
  output logic [CODE_W-1:0] code,
  output logic              is_hex,
  output logic              is_blank
);

  // Table lookup; default covers every illegal pattern.
  always_comb begin
    code     = '0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    unique case (cc)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_A:     code = 4'hA;
      SEG_B:     code = 4'hB;
      SEG_C:     code = 4'hC;
      SEG_D:     code = 4'hD;
      SEG_E:     code = 4'hE;
      SEG_F:     code = 4'hF;
      SEG_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Passive observer of the multiplexed seven-segment bus. Rebuilds the digit frame
// from stable anode/cathode dwells, flags illegal glyphs and signals complete frames.
// Optional watchdog: define SSD_SCAN_TIMEOUT_EN to build the stall detector.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_DIGITS-1:0]        an_in,
  input  logic [SEG_W-1:0]             cc_in,
  output logic [CODE_W*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]        digit_valid,
  output logic                         frame_done,
  output logic                         pattern_err,
  output logic [2:0]                   err_idx,
  output logic                         stall
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Synchroniser stages.
  logic [NUM_DIGITS-1:0] an_s1, an_s2;
  logic [SEG_W-1:0]      cc_s1, cc_s2;

  // Classifier results.
  logic [NUM_DIGITS-1:0] an_low;
  logic                  sample_ok;
  logic [IDX_W-1:0]      sample_idx;

  // Stability tracking.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
  logic [SEG_W-1:0] prev_cc_q, prev_cc_d;
  logic             committed_q, committed_d;
  logic             commit;

  // Decoder outputs.
  logic [CODE_W-1:0] dec_code;
  logic              dec_is_hex;
  logic              dec_is_blank;
  commit_e           commit_kind;

  // Frame state and registered outputs.
  logic [CODE_W*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]        valid_q, valid_d;
  logic [NUM_DIGITS-1:0]        seen_q, seen_d;
  logic                         frame_q, frame_d;
  logic                         perr_q, perr_d;
  logic [2:0]                   err_idx_q, err_idx_d;

  // Watchdog expiry strobe, constant 0 when the watchdog is not built.
  logic wd_fire;

  // Two-flop synchroniser on the asynchronous display bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1 <= '0;
      an_s2 <= '0;
      cc_s1 <= '0;
      cc_s2 <= '0;
    end else begin
      an_s1 <= an_in;
      an_s2 <= an_s1;
      cc_s1 <= cc_in;
      cc_s2 <= cc_s1;
    end
  end

  // Legal sample only when exactly one anode is driven low.
  always_comb begin
    an_low     = ~an_s2;
    sample_ok  = $onehot(an_low);
    sample_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) sample_idx = IDX_W'(i);
    end
  end

  // Dwell counter: one commit per uninterrupted run of an identical (idx, cc) pair.
  always_comb begin
    cnt_d       = cnt_q;
    committed_d = committed_q;
    prev_idx_d  = prev_idx_q;
    prev_cc_d   = prev_cc_q;
    commit      = 1'b0;
    if (!sample_ok) begin
      cnt_d       = '0;
      committed_d = 1'b0;
    end else begin
      prev_idx_d = sample_idx;
      prev_cc_d  = cc_s2;
      if (sample_idx == prev_idx_q && cc_s2 == prev_cc_q) begin
        if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d       = CNT_W'(1);
        committed_d = 1'b0;
      end
      if (cnt_d == CNT_MAX && !committed_d) begin
        commit      = 1'b1;
        committed_d = 1'b1;
      end
    end
  end

  // Stability state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prev_idx_q  <= '0;
      prev_cc_q   <= '0;
      committed_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_idx_q  <= prev_idx_d;
      prev_cc_q   <= prev_cc_d;
      committed_q <= committed_d;
    end
  end

  ssd_seg_decode u_seg_decode (
    .cc       (cc_s2),
    .code     (dec_code),
    .is_hex   (dec_is_hex),
    .is_blank (dec_is_blank)
  );

  // Classify what the current commit does to its slot.
  always_comb begin
    commit_kind = CommitNone;
    if (commit) begin
      if (dec_is_hex)        commit_kind = CommitHex;
      else if (dec_is_blank) commit_kind = CommitBlank;
      else                   commit_kind = CommitErr;
    end
  end

  // Digit slot update, seen-mask tracking and frame completion.
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    err_idx_d = err_idx_q;
    frame_d   = 1'b0;
    perr_d    = 1'b0;
    unique case (commit_kind)
      CommitHex: begin
        digits_d[sample_idx*CODE_W +: CODE_W] = dec_code;
        valid_d[sample_idx]                   = 1'b1;
      end
      CommitBlank: begin
        digits_d[sample_idx*CODE_W +: CODE_W] = '0;
        valid_d[sample_idx]                   = 1'b0;
      end
      CommitErr: begin
        // Keep the last good code so loopback still sees something sensible.
        valid_d[sample_idx] = 1'b0;
        perr_d              = 1'b1;
        err_idx_d           = 3'(sample_idx);
      end
      default: ;
    endcase
    if (commit) begin
      seen_d[sample_idx] = 1'b1;
      if (&seen_d) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end
    if (wd_fire) begin
      valid_d = '0;
      seen_d  = '0;
    end
  end

  // Frame and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      perr_q    <= 1'b0;
      err_idx_q <= '0;
    end else begin
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      perr_q    <= perr_d;
      err_idx_q <= err_idx_d;
    end
  end

`ifdef SSD_SCAN_TIMEOUT_EN
  localparam logic [31:0] WD_MAX = 32'(TIMEOUT_CYCLES);

  logic [31:0] wd_q, wd_d;
  logic        stall_q, stall_d;

  // Cycles since the last commit; saturates so the expiry fires only once.
  always_comb begin
    wd_d    = wd_q;
    stall_d = stall_q;
    wd_fire = 1'b0;
    if (commit) begin
      wd_d    = '0;
      stall_d = 1'b0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 32'd1;
      if (wd_d == WD_MAX) begin
        wd_fire = 1'b1;
        stall_d = 1'b1;
      end
    end
  end

  // Watchdog state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_fire        = 1'b0;
  assign stall          = 1'b0;
`endif

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign pattern_err = perr_q;
  assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: table of dwell records plus hand sequences
// for glitch rejection, watchdog and reset in the middle of a dwell.
module tb_ssd_scan_decoder;

`ifdef SSD_SCAN_TIMEOUT_EN
  localparam int unsigned TMO = 64;
`else
  localparam int unsigned TMO = 1048576;
`endif

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SX = 7'b1111111;
  localparam logic [6:0] SBAD = 7'b1010101;

  logic        clk;
  logic        rst_n;
  logic [7:0]  an_in;
  logic [6:0]  cc_in;
  logic [31:0] digits_out;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        pattern_err;
  logic [2:0]  err_idx;
  logic        stall;

  ssd_scan_decoder #(
    .NUM_DIGITS     (8),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_in       (an_in),
    .cc_in       (cc_in),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pattern_err (pattern_err),
    .err_idx     (err_idx),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: at each rising edge the outputs still show the previous cycle.
  int cyc = 0;
  int err_pulses = 0;
  int frame_pulses = 0;
  int frame_cyc = 0;
  int stall_cycles = 0;
  always @(posedge clk) begin
    if (pattern_err === 1'b1) err_pulses++;
    if (frame_done === 1'b1) begin
      frame_pulses++;
      frame_cyc = cyc;
    end
    if (stall === 1'b1) stall_cycles++;
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  cc;
    int          dwell;
    int          settle;
    logic [31:0] exp_digits;
    logic [7:0]  exp_valid;
    int          exp_err;
    int          exp_frame;
    logic [2:0]  exp_eidx;
  } row_t;

  row_t rows[18];

  // Drive one dwell, idle the bus for the settle time, then compare.
  task automatic apply_row(input int r);
    int e0;
    int f0;
    int start;
    e0    = err_pulses;
    f0    = frame_pulses;
    start = cyc;
    an_in = rows[r].an;
    cc_in = rows[r].cc;
    repeat (rows[r].dwell) @(negedge clk);
    an_in = 8'hFF;
    repeat (rows[r].settle) @(negedge clk);
    check($sformatf("row%0d digits", r), digits_out, rows[r].exp_digits);
    check($sformatf("row%0d valid", r), 32'(digit_valid), 32'(rows[r].exp_valid));
    check($sformatf("row%0d err_pulses", r), 32'(err_pulses - e0), 32'(rows[r].exp_err));
    check($sformatf("row%0d frame_pulses", r), 32'(frame_pulses - f0), 32'(rows[r].exp_frame));
    check($sformatf("row%0d err_idx", r), 32'(err_idx), 32'(rows[r].exp_eidx));
    if (rows[r].exp_frame != 0)
      check($sformatf("row%0d frame_latency", r), 32'(frame_cyc - start), 32'd6);
  endtask

  initial begin
    int e0;
    int n;
    logic saw_bad;

    // Full scan, digit i shows i+1.
    rows[0]  = '{8'hFE, S1, 10, 0, 32'h00000001, 8'h01, 0, 0, 3'd0};
    rows[1]  = '{8'hFD, S2, 10, 0, 32'h00000021, 8'h03, 0, 0, 3'd0};
    rows[2]  = '{8'hFB, S3, 10, 0, 32'h00000321, 8'h07, 0, 0, 3'd0};
    rows[3]  = '{8'hF7, S4, 10, 0, 32'h00004321, 8'h0F, 0, 0, 3'd0};
    rows[4]  = '{8'hEF, S5, 10, 0, 32'h00054321, 8'h1F, 0, 0, 3'd0};
    rows[5]  = '{8'hDF, S6, 10, 0, 32'h00654321, 8'h3F, 0, 0, 3'd0};
    rows[6]  = '{8'hBF, S7, 10, 0, 32'h07654321, 8'h7F, 0, 0, 3'd0};
    rows[7]  = '{8'h7F, S8, 10, 0, 32'h87654321, 8'hFF, 0, 1, 3'd0};
    rows[8]  = '{8'hFE, SA, 10, 0, 32'h8765432A, 8'hFF, 0, 0, 3'd0};
    // Illegal glyph, ghost anodes, blank, then the remaining glyphs.
    rows[9]  = '{8'hDF, SBAD, 6, 6, 32'h87654322, 8'hDF, 1, 0, 3'd5};
    rows[10] = '{8'hF3, S8, 20, 0, 32'h87654322, 8'hDF, 0, 0, 3'd5};
    rows[11] = '{8'hFB, SX, 6, 6, 32'h87654022, 8'hDB, 0, 0, 3'd5};
    rows[12] = '{8'hF7, SE, 8, 0, 32'h8765E022, 8'hDB, 0, 0, 3'd5};
    rows[13] = '{8'hEF, SC, 8, 0, 32'h876CE022, 8'hDB, 0, 0, 3'd5};
    rows[14] = '{8'hBF, SD, 8, 0, 32'h8D6CE022, 8'hDB, 0, 0, 3'd5};
    rows[15] = '{8'h7F, SF, 8, 0, 32'hFD6CE022, 8'hDB, 0, 0, 3'd5};
    rows[16] = '{8'hFD, SB, 8, 0, 32'hFD6CE0B2, 8'hDB, 0, 1, 3'd5};
    rows[17] = '{8'hDF, S0, 8, 0, 32'hFD0CE0B2, 8'hFB, 0, 0, 3'd5};

    // Reset with arbitrary bus activity.
    rst_n = 1'b0;
    an_in = 8'($urandom);
    cc_in = 7'($urandom);
    repeat (3) @(negedge clk);
    check("reset digits", digits_out, 32'h0);
    check("reset valid", 32'(digit_valid), 32'h0);
    check("reset frame_done", 32'(frame_done), 32'h0);
    check("reset pattern_err", 32'(pattern_err), 32'h0);
    check("reset err_idx", 32'(err_idx), 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    an_in = 8'hFF;
    cc_in = SX;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int r = 0; r <= 8; r++) apply_row(r);

    // Glitch: a 3-cycle dwell of "1" must never commit; "2" then commits once.
    e0      = err_pulses;
    saw_bad = 1'b0;
    an_in   = 8'hFE;
    cc_in   = S1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) cc_in = S2;
      if (i == 8) an_in = 8'hFF;
      @(negedge clk);
      if (digits_out[3:0] == 4'h1) saw_bad = 1'b1;
    end
    check("glitch no short commit", 32'(saw_bad), 32'h0);
    check("glitch digits", digits_out, 32'h87654322);
    check("glitch valid", 32'(digit_valid), 32'hFF);
    check("glitch err_pulses", 32'(err_pulses - e0), 32'h0);

    for (int r = 9; r <= 17; r++) apply_row(r);

    // Watchdog on a frozen bus.
    an_in = 8'hFF;
`ifdef SSD_SCAN_TIMEOUT_EN
    n = 0;
    while (stall !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout stall set", 32'(stall), 32'h1);
    check("timeout valid cleared", 32'(digit_valid), 32'h0);
    an_in = 8'hFE;
    cc_in = S3;
    repeat (8) @(negedge clk);
    an_in = 8'hFF;
    repeat (2) @(negedge clk);
    check("timeout stall cleared", 32'(stall), 32'h0);
    check("timeout recommit valid", 32'(digit_valid), 32'h01);
    check("timeout recommit digit", 32'(digits_out[3:0]), 32'h3);
`else
    n = stall_cycles;
    repeat (80) @(negedge clk);
    check("no watchdog stall", 32'(stall_cycles - n), 32'h0);
    check("no watchdog valid", 32'(digit_valid), 32'hFB);
`endif

    // Reset in the middle of a dwell discards the partial count.
    an_in = 8'hF7;
    cc_in = S9;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset digits", digits_out, 32'h0);
    check("midreset valid", 32'(digit_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset no early commit", 32'(digit_valid), 32'h0);
    @(negedge clk);
    check("midreset commit valid", 32'(digit_valid), 32'h08);
    check("midreset commit digits", digits_out, 32'h00009000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the seven-segment encode path.
- Samples the multiplexed anode/cathode bus driving the 8-digit display and decodes active-low segment patterns back to 4-bit hex codes.
- Rebuilds the full digit frame, with a per-digit valid flag, so the alarm-clock self-test and loopback logic can check what is actually on the display.
- Sits beside the display mux; it only observes the bus and never drives it.

Parameters:
- NUM_DIGITS, 8: number of anodes observed.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is committed (legal range 2..255).
- TIMEOUT_CYCLES, 1048576: watchdog limit, used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- an_in  in  NUM_DIGITS  anode enables, active low.
- cc_in  in  7  cathodes, active low; bit0=a … bit6=g.
- digits_out  out  4*NUM_DIGITS  decoded codes; digit i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  1 = digit i holds a decoded hex value.
- frame_done  out  1  one-cycle pulse when every digit has committed since the last pulse.
- pattern_err  out  1  one-cycle pulse when a stable pattern is not a legal code.
- err_idx  out  3  digit index of the last pattern_err; held between errors.
- stall  out  1  watchdog flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0; sync flops, stability counter, seen mask and committed flag cleared.
- Input path:
  - an_in and cc_in pass through a 2-flop synchroniser.
  - All logic below uses the synchronised values.
- Sample classification, every cycle:
  - Exactly one an bit low: legal sample; idx = position of that bit.
  - Zero or more than one an bit low: no sample. The stability counter and committed flag clear; outputs hold.
- Stability:
  - Track the pair (idx, cc) from the previous cycle.
  - A legal sample with the same pair increments the counter, saturating at STABLE_CYCLES.
  - A changed pair restarts the counter at 1 and clears committed.
- Commit:
  - Fires in the cycle the counter reaches STABLE_CYCLES with committed = 0. Set committed = 1, so there is exactly one commit per dwell.
  - Legal hex pattern: digits_out[idx] <= code; digit_valid[idx] <= 1.
  - Blank (7'b1111111): digits_out[idx] <= 0; digit_valid[idx] <= 0.
  - Any other pattern: digit_valid[idx] <= 0; digits_out[idx] holds; pattern_err pulses; err_idx <= idx.
  - Every commit, blank and error included, sets seen[idx].
- Segment table, active low, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Frame:
  - When seen becomes all ones, frame_done pulses in the same cycle the outputs update.
  - seen clears to 0 in that same cycle.
- Latency: a stable anode/cathode change appears on digits_out 2 + STABLE_CYCLES cycles after the pins change.
- Reset mid-dwell discards any partial count. After release, a full STABLE_CYCLES dwell is required again.

Optional Feature:
- Macro: SSD_SCAN_TIMEOUT_EN.
- Defined:
  - A counter increments every cycle and clears on any commit.
  - On reaching TIMEOUT_CYCLES: stall <= 1, all digit_valid <= 0, seen <= 0.
  - stall clears on the next commit.
- Undefined: no counter is built and stall is constant 0.

Decomposition:
- Package ssd_pkg holds:
  - the SEG_0..SEG_F constants and SEG_BLANK, shared with the encode path;
  - SEG_W = 7 and CODE_W = 4.
- Sub-module ssd_seg_decode is purely combinational:
  - input: cc[6:0];
  - outputs: code[3:0], is_hex, is_blank.
- The top level owns the synchroniser, classifier, stability logic, frame logic and watchdog.

Test Plan:
- Reset check: hold rst_n=0, drive arbitrary inputs → all outputs 0.
- Full scan: step an_in one-hot-low through digits 0..7, 10 cycles each, with cc = code for digits 1,2,3,4,5,6,7,8.
  - Expect digits_out = 32'h87654321 and digit_valid = 8'hFF.
  - Expect exactly one frame_done pulse, 2+4 cycles after digit 7's dwell starts.
- Glitch rejection: hold an=11111110, cc=1111001 (1) for 3 cycles, then switch to cc=0100100 (2) for 5 cycles → only 2 commits; digit 0 reads 2.
- Invalid pattern: digit 5 shows cc=1010101 for 6 cycles → pattern_err pulses once, err_idx=5, digit_valid[5]=0, digits_out[5] retains its prior value.
- Ghost anodes: an=11110011 with any cc for 20 cycles → no commit, no pulses, outputs unchanged.
- Blank and timeout:
  - Digit 2 shows cc=1111111 → digit_valid[2]=0 with no error.
  - With SSD_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=64, freeze the bus on an=11111111 → stall=1 and digit_valid=0 at cycle 64; the next commit clears stall.
